// File: rtl/vga_timing_ctrl_pkg.sv
// Shared 640x480@60 VGA timing constants and RGB565 colours, used by the timing
// controller and by the pixel-source stages that feed it.
package vga_timing_ctrl_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [15:0] rgb565_t;

  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_TOTAL   = 800;

  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_TOTAL   = 525;

  localparam int VGA_FRAME_CLOCKS = VGA_H_TOTAL * VGA_V_TOTAL;

  // Coordinate value that tells the pixel source no pixel is being requested
  localparam coord_t NO_COORD = 10'h3FF;

  localparam rgb565_t BLACK   = 16'h0000;
  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t GRAY    = 16'h8410;

  function automatic logic in_window(input coord_t cnt, input coord_t first, input coord_t last);
    return (cnt >= first) && (cnt <= last);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_hv_counter.sv
// Horizontal/vertical raster position counters; the only state in the timing path.
module vga_timing_ctrl_hv_counter
  import vga_timing_ctrl_pkg::*;
#(
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  logic line_end;

  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // The line counter advances on the last clock of each line, wrapping with the frame
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_cnt <= '0;
    end else if (line_end) begin
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: sync pulses, pixel requests one clock ahead of the active
// window, gating of the returned pixel onto rgb, and a frame-start strobe.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_TOTAL     = VGA_H_TOTAL,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_TOTAL     = VGA_V_TOTAL,
  parameter logic SYNC_ACTIVE = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        frame_start
);

  if (H_SYNC + H_BACK + H_DISPLAY + H_FRONT != H_TOTAL) begin : g_bad_h_total
    $error("vga_timing_ctrl: horizontal timing does not add up to H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_DISPLAY + V_FRONT != V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_ctrl: vertical timing does not add up to V_TOTAL");
  end

  localparam coord_t H_SYNC_END  = coord_t'(H_SYNC);
  localparam coord_t V_SYNC_END  = coord_t'(V_SYNC);
  localparam coord_t H_ACT_FIRST = coord_t'(H_SYNC + H_BACK);
  localparam coord_t H_ACT_LAST  = coord_t'(H_SYNC + H_BACK + H_DISPLAY - 1);
  localparam coord_t V_ACT_FIRST = coord_t'(V_SYNC + V_BACK);
  localparam coord_t V_ACT_LAST  = coord_t'(V_SYNC + V_BACK + V_DISPLAY - 1);
  // Requests lead the visible pixel by one clock to cover the source's register stage
  localparam coord_t H_REQ_FIRST = coord_t'(H_SYNC + H_BACK - 1);
  localparam coord_t H_REQ_LAST  = coord_t'(H_SYNC + H_BACK + H_DISPLAY - 2);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       v_active;
  logic       rgb_valid;
  logic       pix_req;

  vga_timing_ctrl_hv_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_hv_counter (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt)
  );

  always_comb begin
    hsync       = (h_cnt < H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync       = (v_cnt < V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_start = (h_cnt == '0) && (v_cnt == '0);

    v_active  = in_window(v_cnt, V_ACT_FIRST, V_ACT_LAST);
    rgb_valid = v_active && in_window(h_cnt, H_ACT_FIRST, H_ACT_LAST);
    pix_req   = v_active && in_window(h_cnt, H_REQ_FIRST, H_REQ_LAST);

    pix_x = NO_COORD;
    pix_y = NO_COORD;
    if (pix_req) begin
      pix_x = h_cnt - H_REQ_FIRST;
      pix_y = v_cnt - V_ACT_FIRST;
    end

    rgb = rgb_valid ? pix_data : BLACK;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: a full-size instance checked over the first 36 lines and a
// scaled-down instance checked over whole frames, both against a raster-position model.
module tb_vga_timing_ctrl;
  import vga_timing_ctrl_pkg::*;

  localparam int AHS = 96, AHB = 48, AHD = 640, AHF = 16;
  localparam int AVS = 2,  AVB = 33, AVD = 480, AVF = 10;
  localparam int BHS = 8,  BHB = 6,  BHD = 20,  BHF = 4;
  localparam int BVS = 2,  BVB = 3,  BVD = 10,  BVF = 2;
  localparam int BHT = BHS + BHB + BHD + BHF;
  localparam int BFRAME = BHT * (BVS + BVB + BVD + BVF);

  typedef struct {
    logic       hs;
    logic       vs;
    logic       fs;
    logic       valid;
    logic [9:0] px;
    logic [9:0] py;
    int         h;
  } exp_t;

  logic        vga_clk;
  logic        rst_a_n, rst_b_n;
  logic [15:0] pix_data_a, pix_data_b;
  logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        hsync_a, vsync_a, hsync_b, vsync_b;
  logic [15:0] rgb_a, rgb_b;
  logic        frame_start_a, frame_start_b;

  int unsigned t_a, t_b;
  int          checks = 0;
  int          errors = 0;
  bit          chk_a = 0, chk_b = 0;
  bit          red_b = 1;
  int          b_phase = 0;
  int          hs_a_cnt = 0, vs_a_cnt = 0, vs_b_cnt = 0;

  vga_timing_ctrl dut_a (
    .vga_clk     (vga_clk),
    .sys_rst_n   (rst_a_n),
    .pix_data    (pix_data_a),
    .pix_x       (pix_x_a),
    .pix_y       (pix_y_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .rgb         (rgb_a),
    .frame_start (frame_start_a)
  );

  vga_timing_ctrl #(
    .H_SYNC (BHS), .H_BACK (BHB), .H_DISPLAY (BHD), .H_FRONT (BHF), .H_TOTAL (BHT),
    .V_SYNC (BVS), .V_BACK (BVB), .V_DISPLAY (BVD), .V_FRONT (BVF),
    .V_TOTAL (BVS + BVB + BVD + BVF), .SYNC_ACTIVE (1'b1)
  ) dut_b (
    .vga_clk     (vga_clk),
    .sys_rst_n   (rst_b_n),
    .pix_data    (pix_data_b),
    .pix_x       (pix_x_b),
    .pix_y       (pix_y_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .rgb         (rgb_b),
    .frame_start (frame_start_b)
  );

  initial begin
    vga_clk = 1'b0;
    forever #20 vga_clk = ~vga_clk;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  // Clock edges seen since reset release: the raster position follows from this alone
  always @(posedge vga_clk or negedge rst_a_n) begin
    if (!rst_a_n) t_a <= 0;
    else          t_a <= t_a + 1;
  end

  always @(posedge vga_clk or negedge rst_b_n) begin
    if (!rst_b_n) t_b <= 0;
    else          t_b <= t_b + 1;
  end

  // Pixel source for the full-size instance: a registered echo of the request column
  always @(posedge vga_clk or negedge rst_a_n) begin
    if (!rst_a_n) pix_data_a <= 16'h0000;
    else          pix_data_a <= {6'b0, pix_x_a};
  end

  initial begin
    pix_data_b = RED;
    forever begin
      @(posedge vga_clk);
      #2;
      pix_data_b = red_b ? RED : 16'($urandom);
    end
  end

  function automatic exp_t model(input int unsigned t, input int hs, input int hb, input int hd,
                                 input int hf, input int vs, input int vb, input int vd, input int vf);
    exp_t e;
    int   ht, vt, h, v;
    bit   v_in, req;
    ht = hs + hb + hd + hf;
    vt = vs + vb + vd + vf;
    h = int'(t % ht);
    v = int'((t / ht) % vt);
    e.h = h;
    e.hs = (h < hs);
    e.vs = (v < vs);
    e.fs = (h == 0) && (v == 0);
    v_in = (v >= vs + vb) && (v < vs + vb + vd);
    e.valid = v_in && (h >= hs + hb) && (h < hs + hb + hd);
    req = v_in && (h + 1 >= hs + hb) && (h + 1 < hs + hb + hd);
    e.px = req ? 10'(h + 1 - (hs + hb)) : 10'h3FF;
    e.py = req ? 10'(v - (vs + vb)) : 10'h3FF;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (t_a=%0d t_b=%0d)", name, act, req, t_a, t_b);
    end
  endtask

  always @(negedge vga_clk) begin
    exp_t ea, eb;
    if (chk_a) begin
      ea = model(t_a, AHS, AHB, AHD, AHF, AVS, AVB, AVD, AVF);
      check("a_hsync", 32'(hsync_a), 32'(ea.hs));
      check("a_vsync", 32'(vsync_a), 32'(ea.vs));
      check("a_frame_start", 32'(frame_start_a), 32'(ea.fs));
      check("a_pix_x", 32'(pix_x_a), 32'(ea.px));
      check("a_pix_y", 32'(pix_y_a), 32'(ea.py));
      check("a_rgb", 32'(rgb_a), ea.valid ? 32'(ea.h - (AHS + AHB)) : 32'h0);
      if (rst_a_n && t_a >= 800 && t_a < 1600 && hsync_a) hs_a_cnt++;
      if (rst_a_n && t_a < 2400 && vsync_a) vs_a_cnt++;
    end
    if (chk_b) begin
      eb = model(t_b, BHS, BHB, BHD, BHF, BVS, BVB, BVD, BVF);
      check("b_hsync", 32'(hsync_b), 32'(eb.hs));
      check("b_vsync", 32'(vsync_b), 32'(eb.vs));
      check("b_frame_start", 32'(frame_start_b), 32'(eb.fs));
      check("b_pix_x", 32'(pix_x_b), 32'(eb.px));
      check("b_pix_y", 32'(pix_y_b), 32'(eb.py));
      check("b_rgb", 32'(rgb_b), eb.valid ? 32'(pix_data_b) : 32'h0);
      if (rst_b_n && b_phase == 0 && t_b < BFRAME && vsync_b) vs_b_cnt++;
    end
  end

  task automatic wait_t(input bit use_b, input int unsigned target);
    int n;
    n = 0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (((use_b ? t_b : t_a) != target) && n < 40000);
    checks++;
    if ((use_b ? t_b : t_a) != target) begin
      errors++;
      $display("[TB] FAIL wait_t actual=%0d required=%0d", use_b ? t_b : t_a, target);
    end
  endtask

  task automatic check_reset_values_b(input string tag);
    check({tag, "_fs"}, 32'(frame_start_b), 32'h1);
    check({tag, "_hs"}, 32'(hsync_b), 32'h1);
    check({tag, "_vs"}, 32'(vsync_b), 32'h1);
    check({tag, "_px"}, 32'(pix_x_b), 32'h3FF);
    check({tag, "_py"}, 32'(pix_y_b), 32'h3FF);
    check({tag, "_rgb"}, 32'(rgb_b), 32'h0);
  endtask

  task automatic run_a();
    wait_t(0, 95);
    check("a_hsync_t95", 32'(hsync_a), 32'h1);
    wait_t(0, 96);
    check("a_hsync_t96", 32'(hsync_a), 32'h0);
    wait_t(0, 34 * 800 + 500);
    check("a_line34_px", 32'(pix_x_a), 32'h3FF);
    check("a_line34_rgb", 32'(rgb_a), 32'h0);
    wait_t(0, 35 * 800 + 142);
    check("a_h142_px", 32'(pix_x_a), 32'h3FF);
    wait_t(0, 35 * 800 + 143);
    check("a_h143_px", 32'(pix_x_a), 32'h0);
    check("a_h143_py", 32'(pix_y_a), 32'h0);
    check("a_h143_rgb", 32'(rgb_a), 32'h0);
    wait_t(0, 35 * 800 + 145);
    check("a_h145_rgb", 32'(rgb_a), 32'h1);
    wait_t(0, 35 * 800 + 782);
    check("a_h782_px", 32'(pix_x_a), 32'd639);
    wait_t(0, 35 * 800 + 783);
    check("a_h783_px", 32'(pix_x_a), 32'h3FF);
    check("a_h783_rgb", 32'(rgb_a), 32'd639);
    wait_t(0, 35 * 800 + 784);
    check("a_h784_rgb", 32'(rgb_a), 32'h0);
    wait_t(0, 36 * 800);
    check("a_hsync_width", 32'(hs_a_cnt), 32'd96);
    check("a_vsync_width", 32'(vs_a_cnt), 32'd1600);
  endtask

  task automatic run_b();
    wait_t(1, 5 * BHT + 13);
    check("b_first_req_rgb", 32'(rgb_b), 32'h0);
    wait_t(1, 5 * BHT + 14);
    check("b_first_red", 32'(rgb_b), 32'hF800);
    wait_t(1, 14 * BHT + 13);
    check("b_last_line_py", 32'(pix_y_b), 32'd9);
    check("b_last_line_px", 32'(pix_x_b), 32'd0);
    wait_t(1, BFRAME);
    check("b_frame_period", 32'(frame_start_b), 32'h1);
    red_b = 0;
    b_phase = 1;
    wait_t(1, BFRAME + 1);
    check("b_frame_pulse_width", 32'(frame_start_b), 32'h0);
    check("b_vsync_width", 32'(vs_b_cnt), 32'(2 * BHT));

    wait_t(1, BFRAME + 9 * BHT + 20);
    check("b_pre_reset_fs", 32'(frame_start_b), 32'h0);
    @(posedge vga_clk);
    #10 rst_b_n = 1'b0;
    #2 check_reset_values_b("b_async_reset");
    repeat (3) @(posedge vga_clk);
    #10 rst_b_n = 1'b1;
    @(negedge vga_clk);
    check_reset_values_b("b_after_release");
    wait_t(1, BFRAME - 1);
    check("b_restart_fs_low", 32'(frame_start_b), 32'h0);
    wait_t(1, BFRAME);
    check("b_restart_period", 32'(frame_start_b), 32'h1);
    wait_t(1, BFRAME + BHT);
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    @(posedge vga_clk);
    chk_a = 1;
    chk_b = 1;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    check("a_rst_fs", 32'(frame_start_a), 32'h1);
    check("a_rst_hs", 32'(hsync_a), 32'h1);
    check("a_rst_vs", 32'(vsync_a), 32'h1);
    check("a_rst_px", 32'(pix_x_a), 32'h3FF);
    check("a_rst_py", 32'(pix_y_a), 32'h3FF);
    check("a_rst_rgb", 32'(rgb_a), 32'h0);
    check_reset_values_b("b_rst");
    @(posedge vga_clk);
    #10;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
